// File: rtl/nbit_abs_subtractor_pkg.sv
// Shared definitions for the chunked absolute subtractor: FSM state encoding
// and the sizing helper for the chunk counter.
package nbit_abs_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of chunk steps for one pass over an operand.
  function automatic int nChunk(input int nBit, input int chunk);
    return nBit / chunk;
  endfunction

  // Counter width; a single-step pass still needs a 1-bit counter.
  function automatic int counterWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nbit_abs_subtractor_if.sv
// Operand/result handshake bundle of the chunked absolute subtractor.
interface nbit_abs_subtractor_if #(
  parameter int nBit = 10
);

  logic            iValid;
  logic            oReady;
  logic [nBit-1:0] iA;
  logic [nBit-1:0] iB;
  logic            iBorrow;
  logic            oValid;
  logic            iReady;
  logic [nBit-1:0] oDiff;
  logic [nBit-1:0] oRes;
  logic            oSign;
  logic            oOvf;

  modport master (
    output iValid, iA, iB, iBorrow, iReady,
    input  oReady, oValid, oDiff, oRes, oSign, oOvf
  );

  modport slave (
    input  iValid, iA, iB, iBorrow, iReady,
    output oReady, oValid, oDiff, oRes, oSign, oOvf
  );

endinterface

// File: rtl/nbit_abs_subtractor_adder.sv
// Plain nBit ripple adder with carry in/out; time-shared by the subtractor
// between the difference pass and the negation pass.
module nBitAdder #(
  parameter int nBit = 2
) (
  input  logic [nBit-1:0] iA,
  input  logic [nBit-1:0] iB,
  input  logic            iCarry,
  output logic [nBit-1:0] oSum,
  output logic            oCarry
);

  assign {oCarry, oSum} = {1'b0, iA} + {1'b0, iB} + {{nBit{1'b0}}, iCarry};

endmodule

// File: rtl/nbit_abs_subtractor.sv
// Multi-cycle chunked subtractor: D = A - B - borrow one CHUNK per cycle,
// followed by a chunked two's-complement negation when D is negative.
module nbit_abs_subtractor
  import nbit_abs_subtractor_pkg::*;
#(
  parameter int nBit  = 10,
  parameter int CHUNK = 2
) (
  input logic                  iClk,
  input logic                  iRstN,
  nbit_abs_subtractor_if.slave bus
);

  localparam int N  = nChunk(nBit, CHUNK);
  localparam int KW = counterWidth(N);

  state_e          stateR;
  state_e          nextStateS;
  logic [nBit-1:0] aR;
  logic [nBit-1:0] bR;
  logic [nBit-1:0] dR;
  logic [nBit-1:0] rR;
  logic [nBit-1:0] diffR;
  logic [nBit-1:0] resR;
  logic            carryR;
  logic            signR;
  logic            ovfR;
  logic            validR;
  logic            readyR;
  logic [KW-1:0]   kR;

  logic [CHUNK-1:0] addAS;
  logic [CHUNK-1:0] addBS;
  logic [CHUNK-1:0] sumS;
  logic             carryOutS;
  logic             lastS;
  logic [nBit-1:0]  dShiftS;
  logic [nBit-1:0]  dRotS;
  logic [nBit-1:0]  rShiftS;

  // Operands are consumed from the low end and results enter at the top, so
  // after N steps the first chunk sits in bits [CHUNK-1:0]. D is rotated
  // during NEG so it is back in place for oDiff when negation finishes.
  assign lastS   = (kR == KW'(N - 1));
  assign dShiftS = nBit'({sumS, dR} >> CHUNK);
  assign dRotS   = nBit'({dR, dR} >> CHUNK);
  assign rShiftS = nBit'({sumS, rR} >> CHUNK);

  // Adder operand selection per phase.
  always_comb begin
    addAS = {CHUNK{1'b0}};
    addBS = {CHUNK{1'b0}};
    case (stateR)
      ST_SUB: begin
        addAS = aR[CHUNK-1:0];
        addBS = ~bR[CHUNK-1:0];
      end
      ST_NEG: begin
        addAS = ~dR[CHUNK-1:0];
        addBS = {CHUNK{1'b0}};
      end
      default: begin
        addAS = {CHUNK{1'b0}};
        addBS = {CHUNK{1'b0}};
      end
    endcase
  end

  nBitAdder #(.nBit(CHUNK)) uAdder (
    .iA     (addAS),
    .iB     (addBS),
    .iCarry (carryR),
    .oSum   (sumS),
    .oCarry (carryOutS)
  );

  // Next-state logic; a missing carry-out of the last SUB chunk means D < 0.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      ST_IDLE: begin
        if (bus.iValid) nextStateS = ST_SUB;
        else            nextStateS = ST_IDLE;
      end
      ST_SUB: begin
        if (lastS) nextStateS = carryOutS ? ST_DONE : ST_NEG;
        else       nextStateS = ST_SUB;
      end
      ST_NEG: begin
        if (lastS) nextStateS = ST_DONE;
        else       nextStateS = ST_NEG;
      end
      ST_DONE: begin
        if (bus.iReady) nextStateS = ST_IDLE;
        else            nextStateS = ST_DONE;
      end
      default: nextStateS = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake/result outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateR <= ST_IDLE;
      aR     <= {nBit{1'b0}};
      bR     <= {nBit{1'b0}};
      dR     <= {nBit{1'b0}};
      rR     <= {nBit{1'b0}};
      diffR  <= {nBit{1'b0}};
      resR   <= {nBit{1'b0}};
      carryR <= 1'b0;
      signR  <= 1'b0;
      ovfR   <= 1'b0;
      validR <= 1'b0;
      readyR <= 1'b1;
      kR     <= {KW{1'b0}};
    end else begin
      stateR <= nextStateS;
      readyR <= (nextStateS == ST_IDLE);
      validR <= (nextStateS == ST_DONE);
      case (stateR)
        ST_IDLE: begin
          if (bus.iValid) begin
            aR     <= bus.iA;
            bR     <= bus.iB;
            carryR <= ~bus.iBorrow;
            kR     <= {KW{1'b0}};
          end
        end
        ST_SUB: begin
          aR <= aR >> CHUNK;
          bR <= bR >> CHUNK;
          dR <= dShiftS;
          if (lastS) begin
            kR     <= {KW{1'b0}};
            carryR <= 1'b1;
            if (carryOutS) begin
              diffR <= dShiftS;
              resR  <= dShiftS;
              signR <= 1'b0;
              ovfR  <= 1'b0;
            end
          end else begin
            kR     <= kR + KW'(1);
            carryR <= carryOutS;
          end
        end
        ST_NEG: begin
          rR <= rShiftS;
          dR <= dRotS;
          if (lastS) begin
            kR    <= {KW{1'b0}};
            diffR <= dRotS;
            resR  <= rShiftS;
            signR <= 1'b1;
            ovfR  <= (rShiftS == {nBit{1'b0}});
          end else begin
            kR     <= kR + KW'(1);
            carryR <= carryOutS;
          end
        end
        ST_DONE: begin
          kR <= {KW{1'b0}};
        end
        default: begin
          kR <= {KW{1'b0}};
        end
      endcase
    end
  end

  assign bus.oReady = readyR;
  assign bus.oValid = validR;
  assign bus.oDiff  = diffR;
  assign bus.oRes   = resR;
  assign bus.oSign  = signR;
  assign bus.oOvf   = ovfR;

endmodule

// File: tb/tb_nbit_abs_subtractor.sv
// Scoreboard bench for nbit_abs_subtractor: CHUNK=2 instance fully exercised,
// CHUNK=1 and CHUNK=10 instances checked on the directed value cases.
module tb_nbit_abs_subtractor;

  localparam int NB = 10;

  typedef struct packed {
    logic [NB-1:0] diff;
    logic [NB-1:0] res;
    logic          sign;
    logic          ovf;
  } expT;

  logic          clk = 1'b0;
  logic          rstN;
  logic          drvValid;
  logic [NB-1:0] drvA;
  logic [NB-1:0] drvB;
  logic          drvBorrow;
  logic          drvReady;

  expT sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;

  nbit_abs_subtractor_if #(.nBit(NB)) bus1 ();
  nbit_abs_subtractor_if #(.nBit(NB)) bus2 ();
  nbit_abs_subtractor_if #(.nBit(NB)) bus10 ();

  assign bus1.iValid   = drvValid;
  assign bus1.iA       = drvA;
  assign bus1.iB       = drvB;
  assign bus1.iBorrow  = drvBorrow;
  assign bus1.iReady   = drvReady;
  assign bus2.iValid   = drvValid;
  assign bus2.iA       = drvA;
  assign bus2.iB       = drvB;
  assign bus2.iBorrow  = drvBorrow;
  assign bus2.iReady   = drvReady;
  assign bus10.iValid  = drvValid;
  assign bus10.iA      = drvA;
  assign bus10.iB      = drvB;
  assign bus10.iBorrow = drvBorrow;
  assign bus10.iReady  = drvReady;

  nbit_abs_subtractor #(.nBit(NB), .CHUNK(1))  dut1  (.iClk(clk), .iRstN(rstN), .bus(bus1));
  nbit_abs_subtractor #(.nBit(NB), .CHUNK(2))  dut2  (.iClk(clk), .iRstN(rstN), .bus(bus2));
  nbit_abs_subtractor #(.nBit(NB), .CHUNK(10)) dut10 (.iClk(clk), .iRstN(rstN), .bus(bus10));

  task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: signed integer arithmetic, then magnitude and wrap.
  function automatic expT refModel(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic bor);
    expT e;
    int full;
    int mag;
    full   = int'(a) - int'(b) - int'(bor);
    mag    = (full < 0) ? -full : full;
    e.diff = NB'(full & 1023);
    e.res  = NB'(mag & 1023);
    e.sign = (full < 0);
    e.ovf  = (mag == 1024);
    return e;
  endfunction

  function automatic int expLat(input int n, input logic s);
    return s ? (2 * n + 1) : (n + 1);
  endfunction

  task automatic popResult(input string tag);
    expT e;
    checkValue({tag, ".sbSize"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkValue({tag, ".diff"}, bus2.oDiff, e.diff);
      checkValue({tag, ".res"},  bus2.oRes,  e.res);
      checkValue({tag, ".sign"}, bus2.oSign, e.sign);
      checkValue({tag, ".ovf"},  bus2.oOvf,  e.ovf);
    end
  endtask

  task automatic waitValid2(output int cyc);
    cyc = 0;
    while (cyc < 60 && !bus2.oValid) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus2.oValid) checkValue("timeoutValid", bus2.oValid, 1);
  endtask

  // Directed case on all three chunk widths; expectations given by the caller.
  task automatic directed(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic bor, input logic [NB-1:0] eDiff, input logic [NB-1:0] eRes,
                          input logic eSign, input logic eOvf);
    int lat1, lat2, lat10, cyc;
    sb.push_back({eDiff, eRes, eSign, eOvf});
    @(negedge clk);
    drvA = a; drvB = b; drvBorrow = bor; drvValid = 1'b1; drvReady = 1'b0;
    lat1 = 0; lat2 = 0; lat10 = 0; cyc = 0;
    while (cyc < 40 && (lat1 == 0 || lat2 == 0 || lat10 == 0)) begin
      @(posedge clk); #1;
      cyc++;
      drvValid = 1'b0;
      if (bus1.oValid && lat1 == 0)   lat1 = cyc;
      if (bus2.oValid && lat2 == 0)   lat2 = cyc;
      if (bus10.oValid && lat10 == 0) lat10 = cyc;
    end
    checkValue({tag, ".lat1"},  lat1,  expLat(10, eSign));
    checkValue({tag, ".lat2"},  lat2,  expLat(5, eSign));
    checkValue({tag, ".lat10"}, lat10, expLat(1, eSign));
    checkValue({tag, ".c1"},  {bus1.oDiff, bus1.oRes, bus1.oSign, bus1.oOvf},     {eDiff, eRes, eSign, eOvf});
    checkValue({tag, ".c10"}, {bus10.oDiff, bus10.oRes, bus10.oSign, bus10.oOvf}, {eDiff, eRes, eSign, eOvf});
    popResult({tag, ".c2"});
    @(negedge clk) drvReady = 1'b1;
    @(negedge clk) drvReady = 1'b0;
    checkValue({tag, ".validDrop"}, bus2.oValid, 0);
    checkValue({tag, ".readyBack"}, bus2.oReady, 1);
  endtask

  initial begin
    int cyc;
    int results;
    logic [NB-1:0] a, b;
    logic bor;
    expT e;

    rstN = 1'b0; drvValid = 1'b0; drvA = '0; drvB = '0; drvBorrow = 1'b0; drvReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("rst.ready", bus2.oReady, 1);
    checkValue("rst.valid", bus2.oValid, 0);
    checkValue("rst.outs",  {bus2.oDiff, bus2.oRes, bus2.oSign, bus2.oOvf}, 0);
    @(negedge clk) rstN = 1'b1;

    directed("c1", 10'd700, 10'd200,  1'b0, 10'd500,  10'd500, 1'b0, 1'b0);
    directed("c2", 10'd5,   10'd9,    1'b1, 10'd1019, 10'd5,   1'b1, 1'b0);
    directed("c3", 10'd0,   10'd1023, 1'b1, 10'd0,    10'd0,   1'b1, 1'b1);
    directed("eq", 10'h155, 10'h155,  1'b0, 10'd0,    10'd0,   1'b0, 1'b0);

    // Stall in DONE with operands offered while busy.
    sb.push_back(refModel(10'd300, 10'd100, 1'b0));
    @(negedge clk);
    drvA = 10'd300; drvB = 10'd100; drvBorrow = 1'b0; drvValid = 1'b1;
    @(posedge clk); #1;
    drvA = 10'd1; drvB = 10'd999; drvBorrow = 1'b1;
    waitValid2(cyc);
    repeat (5) begin
      @(posedge clk); #1;
      checkValue("stall.valid", bus2.oValid, 1);
      checkValue("stall.ready", bus2.oReady, 0);
      checkValue("stall.diff",  bus2.oDiff,  200);
    end
    drvValid = 1'b0;
    popResult("stall");
    @(negedge clk) drvReady = 1'b1;
    @(negedge clk) drvReady = 1'b0;
    @(negedge clk);
    checkValue("stall.idle", bus2.oReady, 1);
    checkValue("stall.noStart", bus2.oValid, 0);

    // Reset during SUB chunk 2, then a fresh operation.
    @(negedge clk);
    drvA = 10'd900; drvB = 10'd17; drvBorrow = 1'b0; drvValid = 1'b1;
    @(posedge clk); #1;
    drvValid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b0;
    #1;
    checkValue("rstMid.valid", bus2.oValid, 0);
    checkValue("rstMid.ready", bus2.oReady, 1);
    checkValue("rstMid.outs",  {bus2.oDiff, bus2.oRes, bus2.oSign, bus2.oOvf}, 0);
    @(negedge clk) rstN = 1'b1;
    sb.push_back(refModel(10'd17, 10'd900, 1'b1));
    @(negedge clk);
    drvA = 10'd17; drvB = 10'd900; drvBorrow = 1'b1; drvValid = 1'b1;
    @(posedge clk); #1;
    drvValid = 1'b0;
    waitValid2(cyc);
    popResult("rstMid.after");
    @(negedge clk) drvReady = 1'b1;
    @(negedge clk) drvReady = 1'b0;

    // Random back-to-back stream with random result stalls.
    results = 0;
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      a   = NB'($urandom_range(0, 1023));
      b   = NB'($urandom_range(0, 1023));
      bor = 1'($urandom_range(0, 1));
      if (i % 10 == 3) begin a = 10'd0; b = 10'd1023; bor = 1'b1; end
      if (i % 10 == 7) begin b = a; bor = 1'b0; end
      drvA = a; drvB = b; drvBorrow = bor; drvValid = 1'b1;
      cyc = 0;
      while (!bus2.oReady && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      @(posedge clk);
      sb.push_back(refModel(a, b, bor));
      #1;
      drvValid = 1'b0; drvReady = 1'b0;
      waitValid2(cyc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        checkValue("rnd.hold", bus2.oValid, 1);
      end
      @(negedge clk);
      popResult("rnd");
      results++;
      drvReady = 1'b1;
      @(posedge clk); #1;
      drvReady = 1'b0;
      checkValue("rnd.dropValid", bus2.oValid, 0);
      @(negedge clk);
    end
    checkValue("rnd.count", results, 30);
    checkValue("rnd.sbEmpty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
